// File: rtl/ace_axi_bus_adapter.sv
//==============================================================================
// Module   : ace_axi_bus_adapter (with package ace_axi_pkg)
// Purpose  : Bridges one ACE slave port onto one plain AXI4 master port.
//            ACE-only request fields are stripped, read responses are
//            zero-extended to the 4-bit ACE RRESP, outstanding reads/writes
//            are tracked until RACK/WACK, and barrier transactions are
//            answered locally without reaching the downstream fabric.
// Ports    : clk_i      - clock
//            rst_ni     - asynchronous reset, active low
//            slv_req_i  - ACE request (AW/W/AR, b_ready, r_ready, rack, wack)
//            slv_resp_o - ACE response (AW/W/AR readies, B, R)
//            mst_req_o  - AXI4 request towards memory
//            mst_resp_i - AXI4 response from memory
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package ace_axi_pkg;
    localparam int unsigned ADDR_WIDTH = 64;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ID_WIDTH   = 4;
    localparam int unsigned USER_WIDTH = 5;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef logic [ID_WIDTH-1:0]   id_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;
    typedef logic [USER_WIDTH-1:0] user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } axi_aw_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } axi_ar_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } axi_w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } axi_b_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } axi_r_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
        logic [2:0] snoop;
        logic [1:0] bar;
        logic [1:0] domain;
        logic       awunique;
    } ace_aw_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
        logic [3:0] snoop;
        logic [1:0] bar;
        logic [1:0] domain;
    } ace_ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [3:0] resp;
        logic       last;
        user_t      user;
    } ace_r_chan_t;

    typedef struct packed {
        ace_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        ace_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
        logic         rack;
        logic         wack;
    } ace_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        ace_r_chan_t r;
    } ace_resp_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_resp_t;
endpackage

module ace_axi_bus_adapter
    import ace_axi_pkg::*;
#(
    parameter int unsigned MAX_RD_TXNS = 8,
    parameter int unsigned MAX_WR_TXNS = 8
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  ace_req_t  slv_req_i,
    output ace_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i
);

    localparam int unsigned c_RD_CNT_W = $clog2(MAX_RD_TXNS + 1);
    localparam int unsigned c_WR_CNT_W = $clog2(MAX_WR_TXNS + 1);
    localparam logic [c_RD_CNT_W-1:0] c_RD_MAX = c_RD_CNT_W'(MAX_RD_TXNS);
    localparam logic [c_WR_CNT_W-1:0] c_WR_MAX = c_WR_CNT_W'(MAX_WR_TXNS);
    localparam logic [c_RD_CNT_W-1:0] c_RD_ONE = c_RD_CNT_W'(1);
    localparam logic [c_WR_CNT_W-1:0] c_WR_ONE = c_WR_CNT_W'(1);

    logic [c_RD_CNT_W-1:0] r_rd_cnt;
    logic [c_WR_CNT_W-1:0] r_wr_cnt;

    // Local barrier response slots. The lock bit keeps a local beat on the
    // bus once it has been presented, so VALID never drops before READY even
    // if a downstream beat shows up in the meantime.
    logic r_rslot_valid;
    logic r_rslot_lock;
    id_t  r_rslot_id;
    logic r_bslot_valid;
    logic r_bslot_lock;
    id_t  r_bslot_id;

    logic w_ar_bar;
    logic w_aw_bar;
    logic w_rd_room;
    logic w_wr_room;
    logic w_ar_ready;
    logic w_aw_ready;
    logic w_ar_hs;
    logic w_aw_hs;
    logic w_rd_dec;
    logic w_wr_dec;
    logic w_r_local;
    logic w_b_local;

    assign w_ar_bar  = slv_req_i.ar.bar[0];
    assign w_aw_bar  = slv_req_i.aw.bar[0];
    assign w_rd_room = (r_rd_cnt < c_RD_MAX);
    assign w_wr_room = (r_wr_cnt < c_WR_MAX);

    // Barriers wait until everything before them is acknowledged and the
    // previous local response has been consumed.
    assign w_ar_ready = w_ar_bar ? ((r_rd_cnt == '0) && !r_rslot_valid)
                                 : (mst_resp_i.ar_ready && w_rd_room);
    assign w_aw_ready = w_aw_bar ? ((r_wr_cnt == '0) && !r_bslot_valid)
                                 : (mst_resp_i.aw_ready && w_wr_room);

    assign w_ar_hs  = slv_req_i.ar_valid && w_ar_ready;
    assign w_aw_hs  = slv_req_i.aw_valid && w_aw_ready;
    assign w_rd_dec = slv_req_i.rack && (r_rd_cnt != '0);
    assign w_wr_dec = slv_req_i.wack && (r_wr_cnt != '0);

    // Downstream beats win unless a local beat is already on the bus.
    assign w_r_local = r_rslot_valid && (r_rslot_lock || !mst_resp_i.r_valid);
    assign w_b_local = r_bslot_valid && (r_bslot_lock || !mst_resp_i.b_valid);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_ar_hs && !w_rd_dec) begin
                r_rd_cnt <= r_rd_cnt + c_RD_ONE;
            end else if (!w_ar_hs && w_rd_dec) begin
                r_rd_cnt <= r_rd_cnt - c_RD_ONE;
            end
            if (w_aw_hs && !w_wr_dec) begin
                r_wr_cnt <= r_wr_cnt + c_WR_ONE;
            end else if (!w_aw_hs && w_wr_dec) begin
                r_wr_cnt <= r_wr_cnt - c_WR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rslot_valid <= 1'b0;
            r_rslot_lock  <= 1'b0;
            r_rslot_id    <= '0;
            r_bslot_valid <= 1'b0;
            r_bslot_lock  <= 1'b0;
            r_bslot_id    <= '0;
        end else begin
            if (w_ar_hs && w_ar_bar) begin
                r_rslot_valid <= 1'b1;
                r_rslot_id    <= slv_req_i.ar.id;
            end else if (w_r_local && slv_req_i.r_ready) begin
                r_rslot_valid <= 1'b0;
                r_rslot_lock  <= 1'b0;
            end else if (w_r_local) begin
                r_rslot_lock  <= 1'b1;
            end

            if (w_aw_hs && w_aw_bar) begin
                r_bslot_valid <= 1'b1;
                r_bslot_id    <= slv_req_i.aw.id;
            end else if (w_b_local && slv_req_i.b_ready) begin
                r_bslot_valid <= 1'b0;
                r_bslot_lock  <= 1'b0;
            end else if (w_b_local) begin
                r_bslot_lock  <= 1'b1;
            end
        end
    end

    always_comb begin
        mst_req_o  = '0;
        slv_resp_o = '0;

        // AR: ACE-only fields (snoop, domain, bar) are simply not copied.
        mst_req_o.ar.id     = slv_req_i.ar.id;
        mst_req_o.ar.addr   = slv_req_i.ar.addr;
        mst_req_o.ar.len    = slv_req_i.ar.len;
        mst_req_o.ar.size   = slv_req_i.ar.size;
        mst_req_o.ar.burst  = slv_req_i.ar.burst;
        mst_req_o.ar.lock   = slv_req_i.ar.lock;
        mst_req_o.ar.cache  = slv_req_i.ar.cache;
        mst_req_o.ar.prot   = slv_req_i.ar.prot;
        mst_req_o.ar.qos    = slv_req_i.ar.qos;
        mst_req_o.ar.region = slv_req_i.ar.region;
        mst_req_o.ar.user   = slv_req_i.ar.user;
        mst_req_o.ar_valid  = slv_req_i.ar_valid && !w_ar_bar && w_rd_room;
        slv_resp_o.ar_ready = w_ar_ready;

        // AW: atop stays at its zero default.
        mst_req_o.aw.id     = slv_req_i.aw.id;
        mst_req_o.aw.addr   = slv_req_i.aw.addr;
        mst_req_o.aw.len    = slv_req_i.aw.len;
        mst_req_o.aw.size   = slv_req_i.aw.size;
        mst_req_o.aw.burst  = slv_req_i.aw.burst;
        mst_req_o.aw.lock   = slv_req_i.aw.lock;
        mst_req_o.aw.cache  = slv_req_i.aw.cache;
        mst_req_o.aw.prot   = slv_req_i.aw.prot;
        mst_req_o.aw.qos    = slv_req_i.aw.qos;
        mst_req_o.aw.region = slv_req_i.aw.region;
        mst_req_o.aw.user   = slv_req_i.aw.user;
        mst_req_o.aw_valid  = slv_req_i.aw_valid && !w_aw_bar && w_wr_room;
        slv_resp_o.aw_ready = w_aw_ready;

        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        slv_resp_o.w_ready = mst_resp_i.w_ready;

        if (w_r_local) begin
            slv_resp_o.r_valid = 1'b1;
            slv_resp_o.r.id    = r_rslot_id;
            slv_resp_o.r.last  = 1'b1;
            mst_req_o.r_ready  = 1'b0;
        end else begin
            slv_resp_o.r_valid = mst_resp_i.r_valid;
            slv_resp_o.r.id    = mst_resp_i.r.id;
            slv_resp_o.r.data  = mst_resp_i.r.data;
            slv_resp_o.r.resp  = {2'b00, mst_resp_i.r.resp};
            slv_resp_o.r.last  = mst_resp_i.r.last;
            slv_resp_o.r.user  = mst_resp_i.r.user;
            mst_req_o.r_ready  = slv_req_i.r_ready;
        end

        if (w_b_local) begin
            slv_resp_o.b_valid = 1'b1;
            slv_resp_o.b.id    = r_bslot_id;
            mst_req_o.b_ready  = 1'b0;
        end else begin
            slv_resp_o.b_valid = mst_resp_i.b_valid;
            slv_resp_o.b       = mst_resp_i.b;
            mst_req_o.b_ready  = slv_req_i.b_ready;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ace_axi_bus_adapter.sv
//==============================================================================
// Module   : tb_ace_axi_bus_adapter
// Purpose  : Self-checking bench for ace_axi_bus_adapter. Inputs change 1 ns
//            after the rising edge, outputs are sampled on the falling edge.
//            Expected R/B beats are queued when stimulus is driven and popped
//            when the adapter presents a handshake on the ACE side.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ace_axi_bus_adapter;
    import ace_axi_pkg::*;

    logic      clk_i = 1'b0;
    logic      rst_ni;
    ace_req_t  slv_req;
    ace_resp_t slv_resp;
    axi_req_t  mst_req;
    axi_resp_t mst_resp;

    int checks = 0;
    int errors = 0;

    ace_r_chan_t r_q[$];
    axi_b_chan_t b_q[$];

    always #5 clk_i = ~clk_i;

    ace_axi_bus_adapter #(
        .MAX_RD_TXNS(8),
        .MAX_WR_TXNS(8)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .slv_req_i (slv_req),
        .slv_resp_o(slv_resp),
        .mst_req_o (mst_req),
        .mst_resp_i(mst_resp)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one AR for a single cycle; the caller makes sure it is accepted.
    task automatic issue_ar(input logic [3:0] id, input logic bar);
        slv_req.ar          = '0;
        slv_req.ar.id       = id;
        slv_req.ar.addr     = 64'h2000 + 64'(id);
        slv_req.ar.bar      = {1'b0, bar};
        slv_req.ar_valid    = 1'b1;
        mst_resp.ar_ready   = 1'b1;
        tick();
        slv_req.ar_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni   = 1'b0;
        slv_req  = '0;
        mst_resp = '0;
        tick();
        tick();
        @(negedge clk_i);
        checks++;
        if ({slv_resp.ar_ready, slv_resp.aw_ready, slv_resp.w_ready,
             slv_resp.r_valid, slv_resp.b_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_slv_flags got %b exp 00000", {slv_resp.ar_ready,
                     slv_resp.aw_ready, slv_resp.w_ready, slv_resp.r_valid, slv_resp.b_valid});
        end
        checks++;
        if ({mst_req.ar_valid, mst_req.aw_valid, mst_req.w_valid,
             mst_req.r_ready, mst_req.b_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mst_flags got %b exp 00000", {mst_req.ar_valid,
                     mst_req.aw_valid, mst_req.w_valid, mst_req.r_ready, mst_req.b_ready});
        end
        checks++;
        if (dut.r_rd_cnt !== 4'd0 || dut.r_wr_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_counters got rd=%0d wr=%0d exp 0/0", dut.r_rd_cnt, dut.r_wr_cnt);
        end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        ace_r_chan_t exp;
        ace_r_chan_t beat;
        slv_req.ar          = '0;
        slv_req.ar.id       = 4'd5;
        slv_req.ar.addr     = 64'h0000_1234_5678_0000;
        slv_req.ar.len      = 8'd3;
        slv_req.ar.size     = 3'd3;
        slv_req.ar.burst    = 2'd1;
        slv_req.ar.user     = 5'h11;
        slv_req.ar.snoop    = 4'hA;
        slv_req.ar.domain   = 2'd2;
        slv_req.ar_valid    = 1'b1;
        mst_resp.ar_ready   = 1'b1;
        @(negedge clk_i);
        checks++;
        if (mst_req.ar_valid !== 1'b1 || slv_resp.ar_ready !== 1'b1 || mst_req.ar.id !== 4'd5 ||
            mst_req.ar.len !== 8'd3 || mst_req.ar.addr !== 64'h0000_1234_5678_0000 ||
            mst_req.ar.user !== 5'h11) begin
            errors++;
            $display("FAIL ar_forward got v=%b r=%b id=%0d len=%0d addr=%0h user=%0h exp 1 1 5 3 123456780000 11",
                     mst_req.ar_valid, slv_resp.ar_ready, mst_req.ar.id, mst_req.ar.len,
                     mst_req.ar.addr, mst_req.ar.user);
        end
        tick();
        slv_req.ar_valid  = 1'b0;
        mst_resp.ar_ready = 1'b0;
        slv_req.r_ready   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mst_resp.r_valid   = 1'b1;
            mst_resp.r.id      = 4'd5;
            mst_resp.r.data    = 64'hA5A5_0000_0000_00A0 + 64'(i);
            mst_resp.r.resp    = 2'(i);
            mst_resp.r.last    = (i == 3);
            mst_resp.r.user    = 5'(i + 1);
            beat.id   = 4'd5;
            beat.data = 64'hA5A5_0000_0000_00A0 + 64'(i);
            beat.resp = {2'b00, 2'(i)};
            beat.last = (i == 3);
            beat.user = 5'(i + 1);
            r_q.push_back(beat);
            @(negedge clk_i);
            checks++;
            if (slv_resp.r_valid && mst_req.r_ready && r_q.size() > 0) begin
                exp = r_q.pop_front();
                if (slv_resp.r !== exp) begin
                    errors++;
                    $display("FAIL read_beat%0d got %0h exp %0h", i, slv_resp.r, exp);
                end
            end else begin
                errors++;
                $display("FAIL read_beat%0d_hs got v=%b mst_rdy=%b exp 1 1", i,
                         slv_resp.r_valid, mst_req.r_ready);
            end
            tick();
        end
        mst_resp.r_valid = 1'b0;
        @(negedge clk_i);
        checks++;
        if (dut.r_rd_cnt !== 4'd1) begin
            errors++;
            $display("FAIL rd_cnt_before_rack got %0d exp 1", dut.r_rd_cnt);
        end
        tick();
        slv_req.rack = 1'b1;
        tick();
        slv_req.rack = 1'b0;
        @(negedge clk_i);
        checks++;
        if (dut.r_rd_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rd_cnt_after_rack got %0d exp 0", dut.r_rd_cnt);
        end
        tick();
    endtask

    task automatic test_ar_limit();
        for (int i = 0; i < 8; i++) issue_ar(4'(i), 1'b0);
        @(negedge clk_i);
        checks++;
        if (dut.r_rd_cnt !== 4'd8) begin
            errors++;
            $display("FAIL rd_cnt_full got %0d exp 8", dut.r_rd_cnt);
        end
        slv_req.ar.id     = 4'd9;
        slv_req.ar_valid  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        @(negedge clk_i);
        checks++;
        if (slv_resp.ar_ready !== 1'b0 || mst_req.ar_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_stall_at_max got rdy=%b mvalid=%b exp 0 0",
                     slv_resp.ar_ready, mst_req.ar_valid);
        end
        tick();
        slv_req.rack = 1'b1;
        tick();
        slv_req.rack = 1'b0;
        @(negedge clk_i);
        checks++;
        if (slv_resp.ar_ready !== 1'b1 || mst_req.ar_valid !== 1'b1 || mst_req.ar.id !== 4'd9) begin
            errors++;
            $display("FAIL ar_resume_after_rack got rdy=%b mvalid=%b id=%0d exp 1 1 9",
                     slv_resp.ar_ready, mst_req.ar_valid, mst_req.ar.id);
        end
        tick();
        slv_req.ar_valid  = 1'b0;
        mst_resp.ar_ready = 1'b0;
        // Drain all eight, plus one extra rack at zero which must be ignored.
        slv_req.rack = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        slv_req.rack = 1'b0;
        @(negedge clk_i);
        checks++;
        if (dut.r_rd_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rd_cnt_no_underflow got %0d exp 0", dut.r_rd_cnt);
        end
        tick();
    endtask

    task automatic test_write();
        axi_b_chan_t exp;
        axi_b_chan_t bb;
        logic [63:0] wd;
        slv_req.aw          = '0;
        slv_req.aw.id       = 4'd2;
        slv_req.aw.addr     = 64'h8000;
        slv_req.aw.len      = 8'd7;
        slv_req.aw.snoop    = 3'd3;
        slv_req.aw.domain   = 2'd1;
        slv_req.aw.awunique = 1'b1;
        slv_req.aw_valid    = 1'b1;
        mst_resp.aw_ready   = 1'b1;
        @(negedge clk_i);
        checks++;
        if (mst_req.aw_valid !== 1'b1 || slv_resp.aw_ready !== 1'b1 || mst_req.aw.id !== 4'd2 ||
            mst_req.aw.len !== 8'd7 || mst_req.aw.atop !== 6'd0 || mst_req.aw.addr !== 64'h8000) begin
            errors++;
            $display("FAIL aw_forward got v=%b r=%b id=%0d len=%0d atop=%0d addr=%0h exp 1 1 2 7 0 8000",
                     mst_req.aw_valid, slv_resp.aw_ready, mst_req.aw.id, mst_req.aw.len,
                     mst_req.aw.atop, mst_req.aw.addr);
        end
        tick();
        slv_req.aw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wd = {32'($urandom), 32'($urandom)};
            slv_req.w_valid   = 1'b1;
            slv_req.w.data    = wd;
            slv_req.w.strb    = 8'hFF;
            slv_req.w.last    = (i == 7);
            mst_resp.w_ready  = (i % 3 != 2);
            @(negedge clk_i);
            checks++;
            if (mst_req.w_valid !== 1'b1 || mst_req.w.data !== wd || mst_req.w.last !== (i == 7) ||
                slv_resp.w_ready !== (i % 3 != 2)) begin
                errors++;
                $display("FAIL w_pass%0d got v=%b data=%0h last=%b rdy=%b exp 1 %0h %b %b", i,
                         mst_req.w_valid, mst_req.w.data, mst_req.w.last, slv_resp.w_ready,
                         wd, (i == 7), (i % 3 != 2));
            end
            tick();
        end
        slv_req.w_valid  = 1'b0;
        mst_resp.w_ready = 1'b0;
        // Second AW handshake in the same cycle as WACK: count must hold at 1.
        slv_req.aw.id    = 4'd4;
        slv_req.aw_valid = 1'b1;
        slv_req.wack     = 1'b1;
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.wack     = 1'b0;
        @(negedge clk_i);
        checks++;
        if (dut.r_wr_cnt !== 4'd1) begin
            errors++;
            $display("FAIL wr_cnt_inc_dec got %0d exp 1", dut.r_wr_cnt);
        end
        mst_resp.aw_ready = 1'b0;
        tick();
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id    = 4'd2;
        mst_resp.b.resp  = 2'b00;
        mst_resp.b.user  = 5'd3;
        slv_req.b_ready  = 1'b1;
        bb.id = 4'd2; bb.resp = 2'b00; bb.user = 5'd3;
        b_q.push_back(bb);
        @(negedge clk_i);
        checks++;
        if (slv_resp.b_valid && mst_req.b_ready && b_q.size() > 0) begin
            exp = b_q.pop_front();
            if (slv_resp.b !== exp) begin
                errors++;
                $display("FAIL b_forward got %0h exp %0h", slv_resp.b, exp);
            end
        end else begin
            errors++;
            $display("FAIL b_forward_hs got v=%b mst_rdy=%b exp 1 1", slv_resp.b_valid, mst_req.b_ready);
        end
        tick();
        mst_resp.b_valid = 1'b0;
        slv_req.b_ready  = 1'b0;
        slv_req.wack     = 1'b1;
        tick();
        slv_req.wack     = 1'b0;
        @(negedge clk_i);
        checks++;
        if (dut.r_wr_cnt !== 4'd0) begin
            errors++;
            $display("FAIL wr_cnt_after_wack got %0d exp 0", dut.r_wr_cnt);
        end
        tick();
    endtask

    task automatic test_rd_barrier();
        ace_r_chan_t exp;
        ace_r_chan_t beat;
        issue_ar(4'd0, 1'b0);
        issue_ar(4'd1, 1'b0);
        slv_req.ar        = '0;
        slv_req.ar.id     = 4'd3;
        slv_req.ar.bar    = 2'b01;
        slv_req.ar_valid  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        @(negedge clk_i);
        checks++;
        if (slv_resp.ar_ready !== 1'b0 || mst_req.ar_valid !== 1'b0) begin
            errors++;
            $display("FAIL rbar_stall_cnt2 got rdy=%b mvalid=%b exp 0 0", slv_resp.ar_ready, mst_req.ar_valid);
        end
        tick();
        slv_req.rack = 1'b1;
        tick();
        @(negedge clk_i);
        checks++;
        if (slv_resp.ar_ready !== 1'b0) begin
            errors++;
            $display("FAIL rbar_stall_cnt1 got rdy=%b exp 0", slv_resp.ar_ready);
        end
        tick();
        slv_req.rack = 1'b0;
        @(negedge clk_i);
        checks++;
        if (slv_resp.ar_ready !== 1'b1 || mst_req.ar_valid !== 1'b0) begin
            errors++;
            $display("FAIL rbar_accept got rdy=%b mvalid=%b exp 1 0", slv_resp.ar_ready, mst_req.ar_valid);
        end
        tick();
        slv_req.ar_valid  = 1'b0;
        mst_resp.ar_ready = 1'b0;
        slv_req.r_ready   = 1'b1;
        beat.id = 4'd3; beat.data = '0; beat.resp = 4'b0000; beat.last = 1'b1; beat.user = '0;
        r_q.push_back(beat);
        @(negedge clk_i);
        checks++;
        if (slv_resp.r_valid && r_q.size() > 0) begin
            exp = r_q.pop_front();
            if (slv_resp.r !== exp || mst_req.r_ready !== 1'b0) begin
                errors++;
                $display("FAIL rbar_local_r got %0h mst_rdy=%b exp %0h 0", slv_resp.r, mst_req.r_ready, exp);
            end
        end else begin
            errors++;
            $display("FAIL rbar_local_r_valid got %b exp 1", slv_resp.r_valid);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if (slv_resp.r_valid !== 1'b0) begin
            errors++;
            $display("FAIL rbar_slot_clear got r_valid=%b exp 0", slv_resp.r_valid);
        end
        tick();
        slv_req.rack = 1'b1;
        tick();
        slv_req.rack = 1'b0;
        slv_req.r_ready = 1'b0;
        tick();
    endtask

    task automatic test_wr_barrier();
        axi_b_chan_t exp;
        axi_b_chan_t bb;
        mst_resp.b_valid  = 1'b1;
        mst_resp.b.id     = 4'd7;
        mst_resp.b.resp   = 2'b00;
        mst_resp.b.user   = 5'd9;
        slv_req.b_ready   = 1'b0;
        slv_req.aw        = '0;
        slv_req.aw.id     = 4'd1;
        slv_req.aw.bar    = 2'b01;
        slv_req.aw_valid  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        @(negedge clk_i);
        checks++;
        if (slv_resp.aw_ready !== 1'b1 || mst_req.aw_valid !== 1'b0) begin
            errors++;
            $display("FAIL wbar_accept got rdy=%b mvalid=%b exp 1 0", slv_resp.aw_ready, mst_req.aw_valid);
        end
        tick();
        slv_req.aw_valid  = 1'b0;
        mst_resp.aw_ready = 1'b0;
        @(negedge clk_i);
        checks++;
        if (slv_resp.b_valid !== 1'b1 || slv_resp.b.id !== 4'd7) begin
            errors++;
            $display("FAIL wbar_downstream_first got v=%b id=%0d exp 1 7", slv_resp.b_valid, slv_resp.b.id);
        end
        tick();
        slv_req.b_ready = 1'b1;
        bb.id = 4'd7; bb.resp = 2'b00; bb.user = 5'd9;
        b_q.push_back(bb);
        bb.id = 4'd1; bb.resp = 2'b00; bb.user = 5'd0;
        b_q.push_back(bb);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            checks++;
            if (slv_resp.b_valid && b_q.size() > 0) begin
                exp = b_q.pop_front();
                if (slv_resp.b !== exp || mst_req.b_ready !== (i == 0)) begin
                    errors++;
                    $display("FAIL wbar_b%0d got %0h mst_rdy=%b exp %0h %b", i, slv_resp.b,
                             mst_req.b_ready, exp, (i == 0));
                end
            end else begin
                errors++;
                $display("FAIL wbar_b%0d_valid got %b exp 1", i, slv_resp.b_valid);
            end
            tick();
            mst_resp.b_valid = 1'b0;
        end
        @(negedge clk_i);
        checks++;
        if (slv_resp.b_valid !== 1'b0 || dut.r_wr_cnt !== 4'd1) begin
            errors++;
            $display("FAIL wbar_done got b_valid=%b wr_cnt=%0d exp 0 1", slv_resp.b_valid, dut.r_wr_cnt);
        end
        tick();
        slv_req.b_ready = 1'b0;
        slv_req.wack    = 1'b1;
        tick();
        slv_req.wack    = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        slv_req.r_ready = 1'b0;
        issue_ar(4'd6, 1'b1);
        for (int i = 0; i < 4; i++) issue_ar(4'(i), 1'b0);
        mst_resp.ar_ready = 1'b0;
        @(negedge clk_i);
        checks++;
        if (dut.r_rd_cnt !== 4'd5 || slv_resp.r_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got rd_cnt=%0d r_valid=%b exp 5 1", dut.r_rd_cnt, slv_resp.r_valid);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (dut.r_rd_cnt !== 4'd0 || slv_resp.r_valid !== 1'b0 || slv_resp.b_valid !== 1'b0 ||
            mst_req.ar_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got rd_cnt=%0d r_valid=%b b_valid=%b ar_valid=%b exp 0 0 0 0",
                     dut.r_rd_cnt, slv_resp.r_valid, slv_resp.b_valid, mst_req.ar_valid);
        end
        tick();
        rst_ni = 1'b1;
        slv_req.rack = 1'b1;
        tick();
        slv_req.rack = 1'b0;
        @(negedge clk_i);
        checks++;
        if (dut.r_rd_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rack_after_reset got %0d exp 0", dut.r_rd_cnt);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_ar_limit();
        test_write();
        test_rd_barrier();
        test_wr_barrier();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
